spi_cmd_sequencer: RTL and testbench

//   Sequences the 8-bit SPI byte transmitter for the bare-metal display path. Owns the panel

---
 rtl/spi_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_sequencer.sv
// Display-path SPI sequencer: panel power-up reset, host word FIFO, per-byte start/D-C control, delays.
// Optional spi_done watchdog enabled by defining SPI_SEQ_TIMEOUT_EN.
module spi_cmd_sequencer #(
    parameter int FIFO_DEPTH = 16,
    parameter int RST_CYCLES = 500000,
    parameter int RST_WAIT   = 6000000,
    parameter int DELAY_UNIT = 50000,
    parameter int GAP_CYCLES = 2
`ifdef SPI_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic       clk_50m,
    input  logic       rst_n,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [9:0] wr_data,
    output logic       busy,
    output logic       init_done,
    output logic       err_timeout,
    output logic       spi_start,
    output logic [7:0] spi_data,
    input  logic       spi_done,
    output logic       lcd_dc,
    output logic       lcd_rst_n
);

    localparam int          AW           = $clog2(FIFO_DEPTH);
    localparam logic [23:0] C_RST_LOAD   = 24'(RST_CYCLES - 1);
    localparam logic [23:0] C_WAIT_LOAD  = 24'(RST_WAIT - 1);
    localparam logic [23:0] C_GAP_LOAD   = 24'(GAP_CYCLES - 1);
    localparam logic [23:0] C_DELAY_UNIT = 24'(DELAY_UNIT);
`ifdef SPI_SEQ_TIMEOUT_EN
    // WAIT_DONE is entered one cycle after spi_start, so the load is two short of TIMEOUT.
    localparam logic [23:0] C_TO_LOAD    = 24'(TIMEOUT - 2);
`endif

    typedef enum logic [2:0] {
        S_RST_HOLD,
        S_RST_WAIT,
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_GAP,
        S_DELAY
    } state_t;

    state_t      r_state;
    logic [23:0] r_cnt;
    logic        r_init_done;
    logic        r_spi_start;
    logic [7:0]  r_spi_data;
    logic        r_lcd_dc;
    logic        r_lcd_rst_n;

    logic [9:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic [9:0]  w_head;
    logic [23:0] w_delay_prod;

    assign w_empty      = (r_wr_ptr == r_rd_ptr);
    assign w_full       = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign wr_ready     = rst_n & ~w_full;
    assign w_push       = wr_valid & wr_ready;
    assign w_pop        = (r_state == S_IDLE) & ~w_empty;
    assign w_head       = r_mem[r_rd_ptr[AW-1:0]];
    assign w_delay_prod = {16'd0, w_head[7:0]} * C_DELAY_UNIT;

    assign busy      = ~w_empty | (r_state != S_IDLE);
    assign init_done = r_init_done;
    assign spi_start = r_spi_start;
    assign spi_data  = r_spi_data;
    assign lcd_dc    = r_lcd_dc;
    assign lcd_rst_n = r_lcd_rst_n;

    always_ff @(posedge clk_50m) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

`ifdef SPI_SEQ_TIMEOUT_EN
    logic r_err_timeout;
    assign err_timeout = r_err_timeout;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_RST_HOLD;
            r_cnt         <= C_RST_LOAD;
            r_init_done   <= 1'b0;
            r_spi_start   <= 1'b0;
            r_spi_data    <= 8'd0;
            r_lcd_dc      <= 1'b0;
            r_lcd_rst_n   <= 1'b0;
`ifdef SPI_SEQ_TIMEOUT_EN
            r_err_timeout <= 1'b0;
`endif
        end else begin
            r_spi_start <= 1'b0;
            case (r_state)
                S_RST_HOLD: begin
                    if (r_cnt == 24'd0) begin
                        r_state     <= S_RST_WAIT;
                        r_cnt       <= C_WAIT_LOAD;
                        r_lcd_rst_n <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                S_RST_WAIT: begin
                    if (r_cnt == 24'd0) begin
                        r_state     <= S_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                S_IDLE: begin
                    if (w_pop) begin
                        case (w_head[9:8])
                            2'b00, 2'b01: begin
                                r_spi_data  <= w_head[7:0];
                                r_lcd_dc    <= w_head[8];
                                r_spi_start <= 1'b1;
                                r_state     <= S_START;
                            end
                            2'b10: begin
                                r_state <= S_DELAY;
                                r_cnt   <= (w_head[7:0] == 8'd0) ? 24'd0 : w_delay_prod - 24'd1;
                            end
                            default: begin
                                r_state     <= S_RST_HOLD;
                                r_cnt       <= C_RST_LOAD;
                                r_lcd_rst_n <= 1'b0;
                            end
                        endcase
                    end
                end
                S_START: begin
                    r_state <= S_WAIT_DONE;
`ifdef SPI_SEQ_TIMEOUT_EN
                    r_cnt   <= C_TO_LOAD;
`endif
                end
                S_WAIT_DONE: begin
                    if (spi_done) begin
                        r_state <= S_GAP;
                        r_cnt   <= C_GAP_LOAD;
`ifdef SPI_SEQ_TIMEOUT_EN
                    end else if (r_cnt == 24'd0) begin
                        r_err_timeout <= 1'b1;
                        r_state       <= S_GAP;
                        r_cnt         <= C_GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
`endif
                    end
                end
                S_GAP, S_DELAY: begin
                    if (r_cnt == 24'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 24'd1;
                    end
                end
                default: begin
                    r_state     <= S_RST_HOLD;
                    r_cnt       <= C_RST_LOAD;
                    r_lcd_rst_n <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer with scaled timing parameters and a model SPI byte engine.
module tb_spi_cmd_sequencer;

    localparam int FD = 16;
    localparam int RC = 20;
    localparam int RW = 40;
    localparam int DU = 10;
    localparam int GP = 2;
`ifdef SPI_SEQ_TIMEOUT_EN
    localparam int TO = 64;
`endif

    logic       clk_50m = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [9:0] wr_data = 10'd0;
    logic       spi_done = 1'b0;
    logic       wr_ready, busy, init_done, err_timeout, spi_start, lcd_dc, lcd_rst_n;
    logic [7:0] spi_data;

    spi_cmd_sequencer #(
        .FIFO_DEPTH(FD), .RST_CYCLES(RC), .RST_WAIT(RW), .DELAY_UNIT(DU), .GAP_CYCLES(GP)
    ) dut (
        .clk_50m(clk_50m), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .busy(busy), .init_done(init_done), .err_timeout(err_timeout),
        .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done), .lcd_dc(lcd_dc),
        .lcd_rst_n(lcd_rst_n)
    );

    initial forever #5 clk_50m = ~clk_50m;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rel_cyc = 0;

    initial forever begin
        @(posedge clk_50m);
        cyc = cyc + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         c;
    } start_t;

    start_t     starts[$];
    int         dones[$];
    int         last_fall = -1, last_rise = -1, fall_cnt = 0, init_rise = -1, init_drop = 0;
    int         stable_err = 0, start_len_err = 0, early_start = 0;
    logic       prev_rst = 1'b0, prev_init = 1'b0, prev_start = 1'b0, in_byte = 1'b0;
    logic [7:0] hold_data = 8'd0;
    logic       hold_dc = 1'b0;

    // Observer: records byte starts/ends and reset/init edges, sampled mid-cycle.
    initial forever begin
        @(negedge clk_50m);
        if (rst_n) begin
            if (spi_start) begin
                start_t s;
                s.data = spi_data; s.dc = lcd_dc; s.c = cyc;
                starts.push_back(s);
                if (prev_start) start_len_err++;
                if (!init_done) early_start++;
                in_byte = 1'b1; hold_data = spi_data; hold_dc = lcd_dc;
            end else if (in_byte) begin
                if (spi_data !== hold_data || lcd_dc !== hold_dc) stable_err++;
                if (spi_done) begin
                    dones.push_back(cyc);
                    in_byte = 1'b0;
                end
            end
            if (prev_rst && !lcd_rst_n) begin last_fall = cyc; fall_cnt++; end
            if (!prev_rst && lcd_rst_n) last_rise = cyc;
            if (!prev_init && init_done) init_rise = cyc;
            if (prev_init && !init_done) init_drop++;
            prev_rst = lcd_rst_n; prev_init = init_done; prev_start = spi_start;
        end
    end

    int eng_lat = 5;
    bit eng_en = 1'b1;
    bit eng_rand = 1'b0;
    int stray_req = 0;
    int stray_ack = 0;

    // Model byte engine: spi_done arrives lat cycles after the spi_start cycle.
    initial forever begin
        int lat;
        @(negedge clk_50m);
        if (stray_ack != stray_req) begin
            @(posedge clk_50m); #1 spi_done = 1'b1;
            @(posedge clk_50m); #1 spi_done = 1'b0;
            stray_ack++;
        end else if (spi_start && eng_en) begin
            lat = eng_rand ? int'($urandom_range(1, 12)) : eng_lat;
            repeat (lat) @(posedge clk_50m);
            #1 spi_done = 1'b1;
            @(posedge clk_50m); #1 spi_done = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [9:0] w, output bit ok);
        ok = 1'b0;
        @(negedge clk_50m);
        wr_valid = 1'b1; wr_data = w;
        for (int n = 0; n < 5000; n++) begin
            if (wr_ready) begin
                @(posedge clk_50m); #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk_50m);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk_50m);
            if (!busy && !in_byte) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk_50m);
        @(negedge clk_50m);
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL rst_wr_ready: got %b want 0", wr_ready); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL rst_init_done: got %b want 0", init_done); end
        n_cmp++; if ({spi_start, spi_data, lcd_dc} !== 10'd0) begin n_err++; $display("FAIL rst_spi: got start=%b data=%h dc=%b want 0", spi_start, spi_data, lcd_dc); end
        n_cmp++; if (lcd_rst_n !== 1'b0) begin n_err++; $display("FAIL rst_lcd_rst_n: got %b want 0", lcd_rst_n); end
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL rst_err_timeout: got %b want 0", err_timeout); end
        rst_n = 1'b1;
        rel_cyc = cyc;
        @(negedge clk_50m);
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL rel_wr_ready: got %b want 1", wr_ready); end
    endtask

    task automatic test_powerup_cmd();
        bit ok;
        eng_rand = 1'b0; eng_lat = 34;
        push(10'h0AF, ok);
        n_cmp++; if (lcd_rst_n !== 1'b0 || ok !== 1'b1) begin n_err++; $display("FAIL pwr_push_in_hold: got ok=%b lcd_rst_n=%b want 1/0", ok, lcd_rst_n); end
        ok = 1'b0;
        for (int n = 0; n < RC + RW + 20; n++) begin
            @(negedge clk_50m);
            if (init_done) begin ok = 1'b1; break; end
        end
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL pwr_init_timeout: init_done got %b want 1", init_done); end
        n_cmp++; if (last_rise - rel_cyc !== RC) begin n_err++; $display("FAIL pwr_rst_low: got %0d want %0d", last_rise - rel_cyc, RC); end
        n_cmp++; if (init_rise - last_rise !== RW) begin n_err++; $display("FAIL pwr_settle: got %0d want %0d", init_rise - last_rise, RW); end
        wait_idle(500, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL pwr_idle: got busy=%b want 0", busy); end
        n_cmp++; if (starts.size() !== 1 || dones.size() !== 1) begin n_err++; $display("FAIL pwr_count: got %0d/%0d want 1/1", starts.size(), dones.size()); end
        if (starts.size() > 0) begin
            n_cmp++; if ({starts[0].dc, starts[0].data} !== 9'h0AF) begin n_err++; $display("FAIL pwr_byte: got %h want 0af", {starts[0].dc, starts[0].data}); end
            n_cmp++; if (starts[0].c - init_rise !== 1) begin n_err++; $display("FAIL pwr_latency: got %0d want 1", starts[0].c - init_rise); end
        end
        n_cmp++; if (early_start !== 0) begin n_err++; $display("FAIL pwr_early_start: got %0d want 0", early_start); end
        n_cmp++; if (stable_err !== 0) begin n_err++; $display("FAIL pwr_stable: got %0d want 0", stable_err); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp_b[$];
        bit ok;
        int base, bdone, nb;
        logic [7:0] arg;
        base = starts.size(); bdone = dones.size();
        eng_rand = 1'b0; eng_lat = 200;
        arg = 8'($urandom);
        exp_b.push_back({1'b1, arg});
        push({2'b01, arg}, ok);
        for (int n = 0; n < 10 && starts.size() == base; n++) @(negedge clk_50m);
        eng_rand = 1'b1;
        for (int i = 0; i < FD; i++) begin
            arg = 8'($urandom);
            exp_b.push_back({1'b1, arg});
            push({2'b01, arg}, ok);
        end
        @(negedge clk_50m);
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL b2b_full_ready: got %b want 0", wr_ready); end
        arg = 8'($urandom);
        exp_b.push_back({1'b1, arg});
        push({2'b01, arg}, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_17th_push: got %b want 1", ok); end
        wait_idle(6000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got busy=%b want 0", busy); end
        nb = starts.size() - base;
        n_cmp++; if (nb !== exp_b.size()) begin n_err++; $display("FAIL b2b_count: got %0d want %0d", nb, exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < nb; i++) begin
            n_cmp++; if ({starts[base+i].dc, starts[base+i].data} !== exp_b[i]) begin n_err++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, {starts[base+i].dc, starts[base+i].data}, exp_b[i]); end
            if (i > 0 && bdone + i - 1 < dones.size()) begin
                n_cmp++; if (starts[base+i].c - dones[bdone+i-1] !== GP + 2) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", i, starts[base+i].c - dones[bdone+i-1], GP + 2); end
            end
        end
        n_cmp++; if (start_len_err !== 0 || stable_err !== 0) begin n_err++; $display("FAIL b2b_pulse_stable: got %0d/%0d want 0/0", start_len_err, stable_err); end
    endtask

    task automatic test_delay();
        bit ok;
        int base, bdone, d;
        logic [7:0] a, b, c;
        base = starts.size(); bdone = dones.size();
        eng_rand = 1'b0; eng_lat = 20;
        d = $urandom_range(1, 4);
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        push({2'b01, a}, ok);
        push({2'b10, 8'(d)}, ok);
        push({2'b01, b}, ok);
        push(10'h200, ok);
        push({2'b00, c}, ok);
        wait_idle(1000, ok);
        n_cmp++; if (starts.size() - base !== 3 || dones.size() - bdone !== 3) begin n_err++; $display("FAIL dly_count: got %0d want 3", starts.size() - base); end
        if (starts.size() - base == 3 && dones.size() - bdone == 3) begin
            n_cmp++; if (starts[base+1].c - dones[bdone] !== GP + 2 + d * DU + 1) begin n_err++; $display("FAIL dly_arg%0d: got %0d want %0d", d, starts[base+1].c - dones[bdone], GP + 2 + d * DU + 1); end
            n_cmp++; if (starts[base+2].c - dones[bdone+1] !== GP + 2 + 2) begin n_err++; $display("FAIL dly_arg0: got %0d want %0d", starts[base+2].c - dones[bdone+1], GP + 4); end
            n_cmp++; if ({starts[base+1].dc, starts[base+1].data, starts[base+2].dc, starts[base+2].data} !== {1'b1, b, 1'b0, c}) begin n_err++; $display("FAIL dly_bytes: got %h %h want %h %h", starts[base+1].data, starts[base+2].data, b, c); end
        end
    endtask

    task automatic test_panel_reset();
        bit ok;
        int base, bdone, fc;
        logic [7:0] a, b, c;
        base = starts.size(); bdone = dones.size(); fc = fall_cnt;
        eng_rand = 1'b0; eng_lat = 10;
        a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        push({2'b01, a}, ok);
        push(10'h300, ok);
        push({2'b01, b}, ok);
        push({2'b00, c}, ok);
        wait_idle(RC + RW + 500, ok);
        n_cmp++; if (fall_cnt - fc !== 1) begin n_err++; $display("FAIL prst_falls: got %0d want 1", fall_cnt - fc); end
        n_cmp++; if (last_rise - last_fall !== RC) begin n_err++; $display("FAIL prst_low: got %0d want %0d", last_rise - last_fall, RC); end
        n_cmp++; if (init_drop !== 0 || init_done !== 1'b1) begin n_err++; $display("FAIL prst_init_kept: got drops=%0d init=%b want 0/1", init_drop, init_done); end
        n_cmp++; if (starts.size() - base !== 3 || dones.size() - bdone !== 3) begin n_err++; $display("FAIL prst_count: got %0d want 3", starts.size() - base); end
        if (starts.size() - base == 3 && dones.size() - bdone == 3) begin
            n_cmp++; if (last_fall - dones[bdone] !== GP + 2) begin n_err++; $display("FAIL prst_fall_time: got %0d want %0d", last_fall - dones[bdone], GP + 2); end
            n_cmp++; if (starts[base+1].c - last_rise !== RW + 1) begin n_err++; $display("FAIL prst_resume: got %0d want %0d", starts[base+1].c - last_rise, RW + 1); end
            n_cmp++; if ({starts[base+1].dc, starts[base+1].data, starts[base+2].dc, starts[base+2].data} !== {1'b1, b, 1'b0, c}) begin n_err++; $display("FAIL prst_bytes: got %h %h want %h %h", starts[base+1].data, starts[base+2].data, b, c); end
        end
    endtask

    task automatic test_stray_done();
        int n;
        n = starts.size();
        stray_req++;
        repeat (8) @(negedge clk_50m);
        n_cmp++; if (starts.size() !== n || busy !== 1'b0) begin n_err++; $display("FAIL stray_done: got starts=%0d busy=%b want %0d/0", starts.size(), busy, n); end
    endtask

    task automatic test_random();
        logic [9:0] words[$];
        logic [8:0] exp_b[$];
        int exp_gap[$];
        int acc, base, bdone, nb;
        bit have_prev, ok, all_ok;
        base = starts.size(); bdone = dones.size();
        eng_rand = 1'b1; acc = 0; have_prev = 1'b0; all_ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] op;
            logic [7:0] arg;
            op = 2'($urandom_range(0, 2));
            arg = 8'($urandom);
            if (op == 2'b10) begin
                arg = 8'($urandom_range(0, 2));
                acc += ((arg == 8'd0) ? 1 : int'(arg) * DU) + 1;
            end else begin
                if (have_prev) exp_gap.push_back(GP + 2 + acc);
                have_prev = 1'b1; acc = 0;
                exp_b.push_back({op[0], arg});
            end
            words.push_back({op, arg});
        end
        foreach (words[i]) begin
            push(words[i], ok);
            all_ok &= ok;
        end
        n_cmp++; if (all_ok !== 1'b1) begin n_err++; $display("FAIL rnd_push: got %b want 1", all_ok); end
        wait_idle(20000, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rnd_idle: got busy=%b want 0", busy); end
        nb = starts.size() - base;
        n_cmp++; if (nb !== exp_b.size()) begin n_err++; $display("FAIL rnd_count: got %0d want %0d", nb, exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < nb; i++) begin
            n_cmp++; if ({starts[base+i].dc, starts[base+i].data} !== exp_b[i]) begin n_err++; $display("FAIL rnd_byte[%0d]: got %h want %h", i, {starts[base+i].dc, starts[base+i].data}, exp_b[i]); end
            if (i > 0 && bdone + i - 1 < dones.size()) begin
                n_cmp++; if (starts[base+i].c - dones[bdone+i-1] !== exp_gap[i-1]) begin n_err++; $display("FAIL rnd_gap[%0d]: got %0d want %0d", i, starts[base+i].c - dones[bdone+i-1], exp_gap[i-1]); end
            end
        end
        n_cmp++; if (start_len_err !== 0 || stable_err !== 0) begin n_err++; $display("FAIL rnd_pulse_stable: got %0d/%0d want 0/0", start_len_err, stable_err); end
    endtask

`ifdef SPI_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        int base, sx, ex;
        logic [7:0] y;
        base = starts.size();
        eng_rand = 1'b0; eng_lat = 5; eng_en = 1'b0;
        push(10'h1A5, ok);
        for (int n = 0; n < 10 && starts.size() == base; n++) @(negedge clk_50m);
        sx = (starts.size() > base) ? starts[base].c : cyc;
        ex = -1;
        for (int n = 0; n < TO + 10; n++) begin
            @(negedge clk_50m);
            if (err_timeout) begin ex = cyc; break; end
        end
        n_cmp++; if (ex - sx !== TO) begin n_err++; $display("FAIL to_latency: got %0d want %0d", ex - sx, TO); end
        eng_en = 1'b1;
        y = 8'($urandom);
        push({2'b01, y}, ok);
        wait_idle(500, ok);
        n_cmp++; if (starts.size() - base !== 2 || err_timeout !== 1'b1) begin n_err++; $display("FAIL to_next_byte: got starts=%0d err=%b want 2/1", starts.size() - base, err_timeout); end
        if (starts.size() - base == 2) begin
            n_cmp++; if (starts[base+1].data !== y) begin n_err++; $display("FAIL to_next_data: got %h want %h", starts[base+1].data, y); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_powerup_cmd();
        test_back_to_back();
        test_delay();
        test_panel_reset();
        test_stray_done();
        test_random();
`ifdef SPI_SEQ_TIMEOUT_EN
        test_timeout();
`else
        n_cmp++; if (err_timeout !== 1'b0) begin n_err++; $display("FAIL err_tied_low: got %b want 0", err_timeout); end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
